// File: rtl/hsv_core_pkg.sv
// Shared constants for the hsv core control/status logic.
// Holds the machine interrupt codes written into mcause.CODE.
package hsv_core_pkg;

    localparam logic [4:0] IRQ_CODE_MSI  = 5'd3;
    localparam logic [4:0] IRQ_CODE_MTI  = 5'd7;
    localparam logic [4:0] IRQ_CODE_MEI  = 5'd11;
    localparam logic [4:0] IRQ_CODE_NONE = 5'd0;

endpackage

// File: rtl/hsv_core_ctrlstatus_irq_sync.sv
// One external interrupt line: synchronizer chain, optional rising-edge
// detect and the pending flop. In edge mode a new edge beats a retire-clear
// that lands in the same cycle, so a re-assertion is never lost.
module hsv_core_ctrlstatus_irq_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE        = 1'b0
) (
    input  logic i_clk_core,
    input  logic i_rst_core,
    input  logic i_async_in,
    input  logic i_clear,
    output logic o_pend
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic                   r_pend;
    logic                   w_sync_out;
    logic                   w_rise;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_sync_out & ~r_sync_prev;
    assign o_pend     = r_pend;

    // Bring the asynchronous pin into the core clock domain and keep its last value for edge detect.
    always_ff @(posedge i_clk_core or posedge i_rst_core) begin
        if (i_rst_core) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], i_async_in};
            r_sync_prev <= w_sync_out;
        end
    end

    // Pending flop: follows the synchronized level, or latches edges until retired (set wins over clear).
    always_ff @(posedge i_clk_core or posedge i_rst_core) begin
        if (i_rst_core) begin
            r_pend <= 1'b0;
        end else if (EDGE) begin
            if (w_rise) begin
                r_pend <= 1'b1;
            end else if (i_clear) begin
                r_pend <= 1'b0;
            end
        end else begin
            r_pend <= w_sync_out;
        end
    end

endmodule

// File: rtl/hsv_core_ctrlstatus_irq_arbiter.sv
// Machine interrupt arbiter: gathers external, software and timer requests,
// picks one by priority (MEI > MSI > MTI, lowest external index first) and
// offers it to the control/status fsm. The cause is frozen while the fsm is
// committing the trap, and an edge-latched external source is retired after.
module hsv_core_ctrlstatus_irq_arbiter
    import hsv_core_pkg::*;
#(
    parameter int                 NUM_EXT     = 4,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_EXT-1:0] EXT_EDGE    = '0,
    localparam int                ID_W        = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1
) (
    input  logic               i_clk_core,
    input  logic               i_rst_core,
    input  logic [NUM_EXT-1:0] i_irq_ext,
    input  logic               i_irq_timer,
    input  logic               i_irq_soft,
    input  logic [NUM_EXT-1:0] i_ext_enable,
    input  logic               i_mie_meie,
    input  logic               i_mie_mtie,
    input  logic               i_mie_msie,
    input  logic               i_irq_lock,
    input  logic               i_irq_taken,
    output logic               o_irq,
    output logic [4:0]         o_irq_cause,
    output logic [ID_W-1:0]    o_irq_ext_id,
    output logic [2:0]         o_mip
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_LOCKED,
        ST_RETIRE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [4:0]         r_irq_cause;
    logic [ID_W-1:0]    r_irq_ext_id;
    logic [2:0]         r_mip;
    logic [NUM_EXT-1:0] w_pend;
    logic [NUM_EXT-1:0] w_clear;
    logic [NUM_EXT-1:0] w_ext_masked;
    logic               w_meip;
    logic               w_act_e;
    logic               w_act_s;
    logic               w_act_t;
    logic               w_any;
    logic [4:0]         w_win_cause;
    logic [ID_W-1:0]    w_win_id;
    logic               w_load;
    logic               w_irq;

    for (genvar gi = 0; gi < NUM_EXT; gi++) begin : g_ext
        assign w_clear[gi] = (r_state == ST_RETIRE) && (r_irq_cause == IRQ_CODE_MEI)
                             && (r_irq_ext_id == ID_W'(gi));

        hsv_core_ctrlstatus_irq_sync #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE        (EXT_EDGE[gi])
        ) u_sync (
            .i_clk_core  (i_clk_core),
            .i_rst_core  (i_rst_core),
            .i_async_in  (i_irq_ext[gi]),
            .i_clear     (w_clear[gi]),
            .o_pend      (w_pend[gi])
        );
    end

    assign w_ext_masked = w_pend & i_ext_enable;
    assign w_meip       = |w_ext_masked;
    assign w_act_e      = w_meip & i_mie_meie;
    assign w_act_s      = i_irq_soft & i_mie_msie;
    assign w_act_t      = i_irq_timer & i_mie_mtie;
    assign w_any        = w_act_e | w_act_s | w_act_t;

    assign o_irq        = w_irq;
    assign o_irq_cause  = r_irq_cause;
    assign o_irq_ext_id = r_irq_ext_id;
    assign o_mip        = r_mip;

    // Pick the winning source: fixed class priority, lowest enabled pending external line.
    always_comb begin
        w_win_id    = '0;
        w_win_cause = IRQ_CODE_NONE;
        for (int i = NUM_EXT - 1; i >= 0; i--) begin
            if (w_ext_masked[i]) begin
                w_win_id = ID_W'(i);
            end
        end
        if (w_act_e) begin
            w_win_cause = IRQ_CODE_MEI;
        end else if (w_act_s) begin
            w_win_cause = IRQ_CODE_MSI;
        end else if (w_act_t) begin
            w_win_cause = IRQ_CODE_MTI;
        end
    end

    // Offer handshake with the fsm: next state, irq request and when the cause register follows the winner.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_irq        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_next = ST_OFFER;
                    w_load       = 1'b1;
                end
            end
            ST_OFFER: begin
                w_irq = 1'b1;
                if (i_irq_lock) begin
                    w_state_next = ST_LOCKED;
                end else if (!w_any) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_load = 1'b1;
                end
            end
            ST_LOCKED: begin
                w_irq = 1'b1;
                if (i_irq_taken) begin
                    w_state_next = ST_RETIRE;
                end else if (!i_irq_lock) begin
                    w_state_next = w_any ? ST_OFFER : ST_IDLE;
                end
            end
            ST_RETIRE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk_core or posedge i_rst_core) begin
        if (i_rst_core) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Cause and external id track the winner while offering, and hold once the fsm locks.
    always_ff @(posedge i_clk_core or posedge i_rst_core) begin
        if (i_rst_core) begin
            r_irq_cause  <= IRQ_CODE_NONE;
            r_irq_ext_id <= '0;
        end else if (w_load) begin
            r_irq_cause  <= w_win_cause;
            r_irq_ext_id <= w_win_id;
        end
    end

    // Raw pending bits for CSR reads, before the mie gating.
    always_ff @(posedge i_clk_core or posedge i_rst_core) begin
        if (i_rst_core) begin
            r_mip <= '0;
        end else begin
            r_mip <= {w_meip, i_irq_timer, i_irq_soft};
        end
    end

endmodule

// File: tb/tb_hsv_core_ctrlstatus_irq_arbiter.sv
// Self-checking bench for the machine interrupt arbiter: directed scenarios
// followed by a randomized run, all compared against a cycle-level model.
module tb_hsv_core_ctrlstatus_irq_arbiter;

    localparam int                 NUM_EXT     = 4;
    localparam int                 SYNC_STAGES = 2;
    localparam logic [NUM_EXT-1:0] EXT_EDGE    = 4'b0110;
    localparam int                 ID_W        = 2;

    localparam int P_IDLE   = 0;
    localparam int P_OFFER  = 1;
    localparam int P_LOCKED = 2;
    localparam int P_RETIRE = 3;

    logic               clock = 1'b0;
    logic               reset;
    logic [NUM_EXT-1:0] irqExt;
    logic               irqTimer;
    logic               irqSoft;
    logic [NUM_EXT-1:0] extEnable;
    logic               mieMeie;
    logic               mieMtie;
    logic               mieMsie;
    logic               irqLock;
    logic               irqTaken;
    logic               irq;
    logic [4:0]         irqCause;
    logic [ID_W-1:0]    irqExtId;
    logic [2:0]         mip;

    int tests  = 0;
    int failed = 0;

    int                 mPhase;
    logic [4:0]         mCause;
    logic [ID_W-1:0]    mId;
    logic [2:0]         mMip;
    logic [NUM_EXT-1:0] mPend;
    logic [NUM_EXT-1:0] pinHist[$];

    hsv_core_ctrlstatus_irq_arbiter #(
        .NUM_EXT     (NUM_EXT),
        .SYNC_STAGES (SYNC_STAGES),
        .EXT_EDGE    (EXT_EDGE)
    ) dut (
        .i_clk_core   (clock),
        .i_rst_core   (reset),
        .i_irq_ext    (irqExt),
        .i_irq_timer  (irqTimer),
        .i_irq_soft   (irqSoft),
        .i_ext_enable (extEnable),
        .i_mie_meie   (mieMeie),
        .i_mie_mtie   (mieMtie),
        .i_mie_msie   (mieMsie),
        .i_irq_lock   (irqLock),
        .i_irq_taken  (irqTaken),
        .o_irq        (irq),
        .o_irq_cause  (irqCause),
        .o_irq_ext_id (irqExtId),
        .o_mip        (mip)
    );

    always #5 clock = ~clock;

    // Model back to its power-on view: nothing pending, nothing offered.
    task automatic modelReset();
        mPhase  = P_IDLE;
        mCause  = 5'd0;
        mId     = '0;
        mMip    = 3'b000;
        mPend   = '0;
        pinHist = {};
        for (int k = 0; k <= SYNC_STAGES; k++) pinHist.push_back('0);
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic modelStep();
        logic [NUM_EXT-1:0] s, sPrev, masked, nextPend;
        logic               meip, actE, actS, actT, any;
        logic [4:0]         winCause;
        logic [ID_W-1:0]    winId;
        int                 nextPhase;
        bit                 load;
        s        = pinHist[SYNC_STAGES-1];
        sPrev    = pinHist[SYNC_STAGES];
        masked   = mPend & extEnable;
        meip     = (masked != 0);
        actE     = meip && mieMeie;
        actS     = irqSoft && mieMsie;
        actT     = irqTimer && mieMtie;
        any      = actE || actS || actT;
        winCause = actE ? 5'd11 : (actS ? 5'd3 : (actT ? 5'd7 : 5'd0));
        winId    = '0;
        for (int i = 0; i < NUM_EXT; i++) begin
            if (masked[i]) begin
                winId = ID_W'(i);
                break;
            end
        end
        for (int i = 0; i < NUM_EXT; i++) begin
            if (!EXT_EDGE[i])
                nextPend[i] = s[i];
            else if (s[i] && !sPrev[i])
                nextPend[i] = 1'b1;
            else if (mPhase == P_RETIRE && mCause == 5'd11 && mId == ID_W'(i))
                nextPend[i] = 1'b0;
            else
                nextPend[i] = mPend[i];
        end
        nextPhase = mPhase;
        load      = 1'b0;
        if (mPhase == P_IDLE) begin
            if (any) begin nextPhase = P_OFFER; load = 1'b1; end
        end else if (mPhase == P_OFFER) begin
            if (irqLock) nextPhase = P_LOCKED;
            else if (!any) nextPhase = P_IDLE;
            else load = 1'b1;
        end else if (mPhase == P_LOCKED) begin
            if (irqTaken) nextPhase = P_RETIRE;
            else if (!irqLock) nextPhase = any ? P_OFFER : P_IDLE;
        end else begin
            nextPhase = P_IDLE;
        end
        if (load) begin
            mCause = winCause;
            mId    = winId;
        end
        mMip   = {meip, irqTimer, irqSoft};
        mPend  = nextPend;
        mPhase = nextPhase;
        pinHist.push_front(irqExt);
        void'(pinHist.pop_back());
    endtask

    // One clock: update the model, take the edge, settle just after it.
    task automatic applyStimulus();
        modelStep();
        @(posedge clock);
        #1;
    endtask

    // Compare one observed value against a fixed scenario expectation.
    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic checkOutput(input string tag);
        logic expIrq;
        expIrq = (mPhase == P_OFFER) || (mPhase == P_LOCKED);
        tests++;
        assert (irq === expIrq) else begin
            failed++;
            $error("[TB] FAIL %s irq: observed %b expected %b", tag, irq, expIrq);
        end
        tests++;
        assert (irqCause === mCause) else begin
            failed++;
            $error("[TB] FAIL %s cause: observed %0d expected %0d", tag, irqCause, mCause);
        end
        tests++;
        assert (irqExtId === mId) else begin
            failed++;
            $error("[TB] FAIL %s ext_id: observed %0d expected %0d", tag, irqExtId, mId);
        end
        tests++;
        assert (mip === mMip) else begin
            failed++;
            $error("[TB] FAIL %s mip: observed %b expected %b", tag, mip, mMip);
        end
    endtask

    // Drop all requests and handshakes and let the arbiter return to idle.
    task automatic quiesce(input string tag);
        irqExt   = '0;
        irqTimer = 1'b0;
        irqSoft  = 1'b0;
        irqLock  = 1'b0;
        irqTaken = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus();
            checkOutput(tag);
        end
    endtask

    initial begin
        logic [NUM_EXT-1:0] flip;
        reset     = 1'b1;
        irqExt    = '0;
        irqTimer  = 1'b0;
        irqSoft   = 1'b0;
        extEnable = '0;
        mieMeie   = 1'b0;
        mieMtie   = 1'b0;
        mieMsie   = 1'b0;
        irqLock   = 1'b0;
        irqTaken  = 1'b0;
        modelReset();

        @(posedge clock);
        @(posedge clock);
        #1;
        checkOutput("reset");
        checkValue("reset_irq", {31'd0, irq}, 32'd0);
        checkValue("reset_mip", {29'd0, mip}, 32'd0);
        reset = 1'b0;
        applyStimulus();
        checkOutput("post_reset");

        // Scenario 1: timer offer, lock, take, retire, re-offer while level stays high.
        irqTimer = 1'b1;
        mieMtie  = 1'b1;
        applyStimulus();
        checkOutput("s1_offer");
        checkValue("s1_irq", {31'd0, irq}, 32'd1);
        checkValue("s1_cause", {27'd0, irqCause}, 32'd7);
        irqLock = 1'b1;
        applyStimulus();
        checkOutput("s1_locked");
        irqTaken = 1'b1;
        applyStimulus();
        checkOutput("s1_retire");
        checkValue("s1_retire_irq", {31'd0, irq}, 32'd0);
        irqLock  = 1'b0;
        irqTaken = 1'b0;
        applyStimulus();
        checkOutput("s1_idle");
        applyStimulus();
        checkOutput("s1_reoffer");
        checkValue("s1_reoffer_irq", {31'd0, irq}, 32'd1);
        quiesce("s1_quiesce");

        // Scenario 2: soft beats timer, then timer takes over once soft drops.
        mieMsie  = 1'b1;
        irqTimer = 1'b1;
        irqSoft  = 1'b1;
        applyStimulus();
        checkOutput("s2_both");
        checkValue("s2_cause_soft", {27'd0, irqCause}, 32'd3);
        irqSoft = 1'b0;
        applyStimulus();
        checkOutput("s2_soft_drop");
        checkValue("s2_cause_timer", {27'd0, irqCause}, 32'd7);
        quiesce("s2_quiesce");

        // Scenario 3: one-cycle pulse on edge line 2 is latched, offered, then retired.
        mieMeie   = 1'b1;
        extEnable = 4'hF;
        irqExt    = 4'b0100;
        applyStimulus();
        checkOutput("s3_e1");
        irqExt = '0;
        applyStimulus();
        checkOutput("s3_e2");
        applyStimulus();
        checkOutput("s3_e3");
        checkValue("s3_irq_e3", {31'd0, irq}, 32'd0);
        applyStimulus();
        checkOutput("s3_e4");
        checkValue("s3_irq_e4", {31'd0, irq}, 32'd1);
        checkValue("s3_cause", {27'd0, irqCause}, 32'd11);
        checkValue("s3_id", {30'd0, irqExtId}, 32'd2);
        irqLock = 1'b1;
        applyStimulus();
        checkOutput("s3_locked");
        irqTaken = 1'b1;
        applyStimulus();
        checkOutput("s3_retire");
        irqLock  = 1'b0;
        irqTaken = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("s3_after");
        end
        checkValue("s3_irq_stays_low", {31'd0, irq}, 32'd0);
        checkValue("s3_meip_clear", {31'd0, mip[2]}, 32'd0);

        // Scenario 4: cause is frozen in LOCKED, re-arbitrated after the lock drops.
        irqTimer = 1'b1;
        applyStimulus();
        checkOutput("s4_offer");
        irqLock = 1'b1;
        applyStimulus();
        checkOutput("s4_locked");
        irqSoft = 1'b1;
        applyStimulus();
        checkOutput("s4_soft_in_lock");
        applyStimulus();
        checkOutput("s4_still_locked");
        checkValue("s4_frozen_cause", {27'd0, irqCause}, 32'd7);
        irqLock = 1'b0;
        applyStimulus();
        checkOutput("s4_unlock");
        applyStimulus();
        checkOutput("s4_rearb");
        checkValue("s4_irq", {31'd0, irq}, 32'd1);
        checkValue("s4_cause_soft", {27'd0, irqCause}, 32'd3);
        quiesce("s4_quiesce");

        // Scenario 5: new edge on line 1 lands in the RETIRE cycle that clears line 1.
        irqExt = 4'b0010;
        applyStimulus();
        checkOutput("s5_pulse");
        irqExt = '0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("s5_sync");
        end
        checkValue("s5_id_first", {30'd0, irqExtId}, 32'd1);
        irqLock = 1'b1;
        applyStimulus();
        checkOutput("s5_locked");
        irqExt = 4'b0010;
        applyStimulus();
        checkOutput("s5_reassert");
        irqExt   = '0;
        irqTaken = 1'b1;
        applyStimulus();
        checkOutput("s5_retire");
        irqLock  = 1'b0;
        irqTaken = 1'b0;
        applyStimulus();
        checkOutput("s5_idle");
        applyStimulus();
        checkOutput("s5_reoffer");
        checkValue("s5_irq", {31'd0, irq}, 32'd1);
        checkValue("s5_cause", {27'd0, irqCause}, 32'd11);
        checkValue("s5_id", {30'd0, irqExtId}, 32'd1);
        checkValue("s5_meip", {31'd0, mip[2]}, 32'd1);
        irqLock = 1'b1;
        applyStimulus();
        checkOutput("s5_lock2");
        irqTaken = 1'b1;
        applyStimulus();
        checkOutput("s5_retire2");
        quiesce("s5_quiesce");

        // Scenario 6: asynchronous reset while LOCKED drops irq and loses a latched edge.
        extEnable = '0;
        irqTimer  = 1'b1;
        irqExt    = 4'b0100;
        applyStimulus();
        checkOutput("s6_offer");
        irqLock = 1'b1;
        irqExt  = '0;
        applyStimulus();
        checkOutput("s6_locked");
        applyStimulus();
        checkOutput("s6_edge_latched");
        applyStimulus();
        checkOutput("s6_meip_seen");
        checkValue("s6_irq_before", {31'd0, irq}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkValue("s6_irq_async", {31'd0, irq}, 32'd0);
        checkValue("s6_mip_async", {29'd0, mip}, 32'd0);
        irqTimer  = 1'b0;
        irqLock   = 1'b0;
        extEnable = 4'hF;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus();
            checkOutput("s6_after_reset");
        end
        checkValue("s6_edge_lost", {31'd0, irq}, 32'd0);

        // Randomized run against the model.
        for (int n = 0; n < 400; n++) begin
            flip = '0;
            if ($urandom_range(0, 5) == 0) flip[$urandom_range(0, NUM_EXT - 1)] = 1'b1;
            irqExt    = irqExt ^ flip;
            irqTimer  = ($urandom_range(0, 3) == 0) ? ~irqTimer : irqTimer;
            irqSoft   = ($urandom_range(0, 3) == 0) ? ~irqSoft : irqSoft;
            extEnable = ($urandom_range(0, 7) == 0) ? NUM_EXT'($urandom) : extEnable;
            mieMeie   = ($urandom_range(0, 9) != 0);
            mieMtie   = ($urandom_range(0, 9) != 0);
            mieMsie   = ($urandom_range(0, 9) != 0);
            irqLock   = ($urandom_range(0, 1) == 1);
            irqTaken  = ($urandom_range(0, 2) == 0);
            applyStimulus();
            checkOutput("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
